mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory between the fetch and load/store ports.
// Each access is held on the bus for WAIT_CYCLES cycles, then acked for one cycle.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } port_t;

    state_t            state, state_nx;
    port_t             port, port_nx;
    port_t             last_grant, last_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic              we_q, we_nx;
    logic              last_cycle;
    logic              capture;

    assign last_cycle = (state == ACCESS) && (cnt == '0);
    assign capture    = last_cycle && !we_q;

    always_comb begin
        state_nx = state;
        port_nx  = port;
        last_nx  = last_grant;
        cnt_nx   = cnt;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        we_nx    = we_q;
        unique case (state)
            IDLE: begin
                // On a tie the port that did not win last time is served.
                if (if_req && (!d_req || last_grant == PORT_D)) begin
                    state_nx = ACCESS;
                    port_nx  = PORT_IF;
                    last_nx  = PORT_IF;
                    cnt_nx   = CW'(WAIT_CYCLES - 1);
                    addr_nx  = if_addr;
                    wdata_nx = '0;
                    we_nx    = 1'b0;
                end else if (d_req) begin
                    state_nx = ACCESS;
                    port_nx  = PORT_D;
                    last_nx  = PORT_D;
                    cnt_nx   = CW'(WAIT_CYCLES - 1);
                    addr_nx  = d_addr;
                    wdata_nx = d_wdata;
                    we_nx    = d_we;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            port       <= PORT_IF;
            last_grant <= PORT_D;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nx;
            port       <= port_nx;
            last_grant <= last_nx;
            cnt        <= cnt_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            we_q       <= we_nx;
            if (capture && port == PORT_IF) begin
                if_rdata <= mem_rdata;
            end
            if (capture && port == PORT_D) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    // Write strobe is gated by rst so a reset edge never commits a store.
    assign mem_read  = (state == ACCESS) && !we_q;
    assign mem_write = last_cycle && we_q && !rst;
    assign mem_addr  = (state == ACCESS) ? addr_q : '0;
    assign mem_wdata = (state == ACCESS) ? wdata_q : '0;
    assign if_ack    = (state == DONE) && (port == PORT_IF);
    assign d_ack     = (state == DONE) && (port == PORT_D);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT_CYCLES 1 and 3) against a
// transaction-level model of arbitration order, latency and memory contents.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic [31:0] if_rdata  [2];
    logic        if_ack    [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic [31:0] d_rdata   [2];
    logic        d_ack     [2];
    logic        mem_read  [2];
    logic        mem_write [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    logic [31:0] mem     [2][1024];
    logic [31:0] ref_mem [2][1024];
    bit          init_done;

    int          errors = 0;
    int          checks = 0;
    bit          last_d [2];
    logic [31:0] mdl_if [2];
    logic [31:0] mdl_d  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .WAIT_CYCLES(g == 0 ? 1 : 3),
            .DATA_W(32),
            .ADDR_W(32)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_rdata (if_rdata[g]),
            .if_ack   (if_ack[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_rdata  (d_rdata[g]),
            .d_ack    (d_ack[g]),
            .mem_read (mem_read[g]),
            .mem_write(mem_write[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );
    end

    function automatic logic [31:0] seed(input int k, input int i);
        return (i * 32'h9E37_79B9) ^ (k << 20) ^ 32'h0123_4567;
    endfunction

    always @(posedge clk) begin
        if (!init_done) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 1024; i++)
                    mem[k][i] <= seed(k, i);
            init_done <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++)
                if (mem_write[k] === 1'b1)
                    mem[k][mem_addr[k][11:2]] <= mem_wdata[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            mem_rdata[k] = '0;
            if (mem_read[k] === 1'b1)
                mem_rdata[k] = mem[k][mem_addr[k][11:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        last_d[k] = 1'b1;
        mdl_if[k] = '0;
        mdl_d[k]  = '0;
    endtask

    task automatic do_reset(input int k);
        @(negedge clk);
        rst[k]    = 1'b1;
        if_req[k] = 1'b0;
        d_req[k]  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy[k], 0);
        check("rst_if_rdata", if_rdata[k], 0);
        check("rst_d_rdata", d_rdata[k], 0);
        check("rst_acks", {if_ack[k], d_ack[k]}, 0);
        check("rst_mem_rw", {mem_read[k], mem_write[k]}, 0);
        check("rst_mem_addr", mem_addr[k], 0);
        rst[k] = 1'b0;
        model_reset(k);
    endtask

    // One arbitration round: f/d select requesters, hold keeps a lone
    // fetch request up one cycle past its ack, scramble perturbs inputs
    // of a lone served port after the grant.
    task automatic txn(input int k, input bit f, input bit d,
                       input bit hold, input bit scramble);
        int w, n, rd, wr, bz, both, nrd, nst, act, lim, drop_at;
        int exp_p[$];
        int exp_t[$];
        int got_p[$];
        int got_t[$];
        logic [31:0] fa, da, dw, wa, ws, ra;
        bit dwe, hold_left;
        w   = (k == 0) ? 1 : 3;
        fa  = if_addr[k];
        da  = d_addr[k];
        dw  = d_wdata[k];
        dwe = d_we[k];
        if (f && d) exp_p = last_d[k] ? '{0, 1} : '{1, 0};
        else if (f) exp_p = '{0};
        else exp_p = '{1};
        if (hold) exp_p.push_back(0);
        nrd = 0;
        nst = 0;
        foreach (exp_p[i]) begin
            exp_t.push_back((w + 1) + i * (w + 2));
            if (exp_p[i] == 0) begin
                mdl_if[k] = ref_mem[k][fa[11:2]];
                nrd++;
            end else if (dwe) begin
                ref_mem[k][da[11:2]] = dw;
                nst++;
            end else begin
                mdl_d[k] = ref_mem[k][da[11:2]];
                nrd++;
            end
            last_d[k] = (exp_p[i] == 1);
        end

        @(negedge clk);
        if_req[k] = f;
        d_req[k]  = d;
        n = 0; rd = 0; wr = 0; bz = 0; both = 0;
        wa = '0; ws = '0; ra = '0;
        hold_left = hold;
        drop_at = -1;
        lim = exp_p.size() * (w + 2) + 4;
        while (got_p.size() < exp_p.size() && n < lim) begin
            @(negedge clk);
            n++;
            if (mem_read[k]) begin rd++; ra = mem_addr[k]; end
            if (mem_write[k]) begin
                wr++;
                wa = mem_addr[k];
                ws = mem_wdata[k];
            end
            if (busy[k]) bz++;
            if (if_ack[k] && d_ack[k]) both++;
            if (if_ack[k]) begin
                got_p.push_back(0);
                got_t.push_back(n);
                if (hold_left) begin
                    hold_left = 1'b0;
                    drop_at = n + 2;
                end else begin
                    if_req[k] = 1'b0;
                end
            end
            if (d_ack[k]) begin
                got_p.push_back(1);
                got_t.push_back(n);
                d_req[k] = 1'b0;
            end
            if (n == drop_at) if_req[k] = 1'b0;
            if (scramble && n == 1 && !(f && d)) begin
                if_addr[k] = $urandom;
                d_addr[k]  = $urandom;
                d_wdata[k] = $urandom;
                d_we[k]    = ~d_we[k];
            end
        end
        if_req[k] = 1'b0;
        d_req[k]  = 1'b0;

        check("ack_count", got_p.size(), exp_p.size());
        foreach (exp_p[i]) begin
            check("ack_port", (i < got_p.size()) ? got_p[i] : -1, exp_p[i]);
            check("ack_time", (i < got_t.size()) ? got_t[i] : -1, exp_t[i]);
        end
        check("rd_cycles", rd, w * nrd);
        check("wr_cycles", wr, nst);
        check("busy_cycles", bz, (w + 1) * exp_p.size());
        check("dual_ack", both, 0);
        if (nst > 0) begin
            check("wr_addr", wa, da);
            check("wr_data", ws, dw);
        end
        if (exp_p.size() == 1 && nst == 0)
            check("rd_addr", ra, (exp_p[0] == 0) ? fa : da);
        check("if_rdata", if_rdata[k], mdl_if[k]);
        check("d_rdata", d_rdata[k], mdl_d[k]);

        act = 0;
        repeat (w + 3) begin
            @(negedge clk);
            if (busy[k] || mem_read[k] || mem_write[k] || if_ack[k] || d_ack[k])
                act++;
        end
        check("quiet_after", act, 0);
    endtask

    task automatic rst_mid(input int k);
        int w, acks, wr;
        w = (k == 0) ? 1 : 3;
        @(negedge clk);
        d_req[k]   = 1'b1;
        d_we[k]    = 1'b1;
        d_addr[k]  = 32'h40;
        d_wdata[k] = 32'h0BAD_F00D;
        @(negedge clk);
        check("mid_busy", busy[k], 1);
        rst[k]   = 1'b1;
        d_req[k] = 1'b0;
        #1;
        check("rst_wr_force", mem_write[k], 0);
        @(negedge clk);
        rst[k] = 1'b0;
        check("mid_rst_busy", busy[k], 0);
        check("mid_rst_if_rdata", if_rdata[k], 0);
        check("mid_rst_d_rdata", d_rdata[k], 0);
        acks = 0;
        wr = 0;
        repeat (w + 3) begin
            @(negedge clk);
            if (if_ack[k] || d_ack[k]) acks++;
            if (mem_write[k]) wr++;
        end
        check("mid_rst_no_ack", acks, 0);
        check("mid_rst_no_wr", wr, 0);
        check("mid_rst_mem", mem[k][16], ref_mem[k][16]);
        model_reset(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            if_req[k] = 1'b0;
            if_addr[k] = '0;
            d_req[k] = 1'b0;
            d_we[k] = 1'b0;
            d_addr[k] = '0;
            d_wdata[k] = '0;
            for (int i = 0; i < 1024; i++) ref_mem[k][i] = seed(k, i);
        end

        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            if (k == 0) begin
                if_addr[0] = 32'h8;
                txn(0, 1, 0, 0, 0);
                check("fetch_word2", if_rdata[0], seed(0, 2));
                d_we[0] = 1'b1;
                d_addr[0] = 32'h7D0;
                d_wdata[0] = 32'hDEAD_BEEF;
                txn(0, 0, 1, 0, 0);
                d_we[0] = 1'b0;
                txn(0, 0, 1, 0, 0);
                check("load_back", d_rdata[0], 32'hDEAD_BEEF);
                check("fetch_kept", if_rdata[0], seed(0, 2));
                repeat (2) begin
                    if_addr[0] = 32'h10;
                    d_addr[0] = 32'h7D0;
                    d_we[0] = 1'b0;
                    txn(0, 1, 1, 0, 0);
                end
                if_addr[0] = 32'h20;
                txn(0, 1, 0, 1, 0);
            end else begin
                if_addr[1] = 32'hC;
                txn(1, 1, 0, 0, 0);
                if_addr[1] = 32'h14;
                d_addr[1] = 32'h14;
                d_we[1] = 1'b1;
                d_wdata[1] = 32'h1234_5678;
                txn(1, 1, 1, 0, 0);
            end
            rst_mid(k);
            repeat (40) begin
                mode = $urandom_range(1, 3);
                if_addr[k] = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                d_addr[k]  = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                d_we[k]    = 1'($urandom_range(0, 1));
                d_wdata[k] = $urandom;
                txn(k, mode[0], mode[1], 0, 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
